// File: rtl/gmii_mac.sv
// GMII RX->TX loopback that forwards only IPv4 frames addressed to ip2, DELAY+1 cycles later.
// No backpressure: a parser decision per frame is queued and applied when the delayed frame head exits.
module gmii_mac #(
    parameter logic [31:0] ip2      = 32'hC0A86466,
    parameter logic [7:0]  SFD      = 8'h5D,
    parameter int          MIN_PRE  = 7,
    parameter int          MAX_VLAN = 2,
    parameter int          DELAY    = 64
) (
    input  logic       rx_clk,
    input  logic       reset,
    input  logic       sys_clk,
    input  logic [7:0] rxd,
    input  logic       rxdv,
    input  logic       rxer,
    output logic       gtx_clk,
    output logic [7:0] txd,
    output logic       txen
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DMAC, S_SMAC, S_ETYPE, S_VLAN, S_IP, S_WAIT
    } state_t;

    localparam logic [4:0] MIN_PRE_W  = 5'(MIN_PRE);
    localparam logic [1:0] MAX_VLAN_W = 2'(MAX_VLAN);

    logic unused_sys_clk;
    assign unused_sys_clk = sys_clk;
    assign gtx_clk        = rx_clk;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  etype_hi_q, etype_hi_d;
    logic [1:0]  vlan_q, vlan_d;
    logic [23:0] dst_q, dst_d;
    logic        push, push_pass, do_drop;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        etype_hi_d = etype_hi_q;
        vlan_d     = vlan_q;
        dst_d      = dst_q;
        push       = 1'b0;
        push_pass  = 1'b0;
        do_drop    = 1'b0;
        if (!rxdv) begin
            // Frame ended before a decision: a truncated frame still owes one DROP.
            if (state_q != S_IDLE && state_q != S_WAIT)
                do_drop = 1'b1;
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (rxd == 8'h55 && !rxer) begin
                state_d = S_PRE;
                cnt_d   = 5'd1;
            end else begin
                do_drop = 1'b1;
            end
        end else if (rxer && state_q != S_WAIT) begin
            do_drop = 1'b1;
        end else begin
            unique case (state_q)
                S_PRE: begin
                    if (rxd == 8'h55) begin
                        if (cnt_q != 5'd31)
                            cnt_d = cnt_q + 5'd1;
                    end else if (rxd == SFD && cnt_q >= MIN_PRE_W) begin
                        state_d = S_DMAC;
                        cnt_d   = 5'd0;
                        vlan_d  = 2'd0;
                    end else begin
                        do_drop = 1'b1;
                    end
                end
                S_DMAC, S_SMAC: begin
                    if (cnt_q == 5'd5) begin
                        state_d = (state_q == S_DMAC) ? S_SMAC : S_ETYPE;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_ETYPE: begin
                    if (cnt_q == 5'd0) begin
                        etype_hi_d = rxd;
                        cnt_d      = 5'd1;
                    end else if ({etype_hi_q, rxd} == 16'h8100 && vlan_q < MAX_VLAN_W) begin
                        state_d = S_VLAN;
                        cnt_d   = 5'd0;
                        vlan_d  = vlan_q + 2'd1;
                    end else if ({etype_hi_q, rxd} == 16'h0800) begin
                        state_d = S_IP;
                        cnt_d   = 5'd0;
                    end else begin
                        do_drop = 1'b1;
                    end
                end
                S_VLAN: begin
                    if (cnt_q == 5'd1) begin
                        state_d = S_ETYPE;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_IP: begin
                    if (cnt_q == 5'd19) begin
                        push      = 1'b1;
                        push_pass = ({dst_q, rxd} == ip2);
                        state_d   = S_WAIT;
                    end else begin
                        if (cnt_q >= 5'd16)
                            dst_d = {dst_q[15:0], rxd};
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
        if (do_drop) begin
            push      = 1'b1;
            push_pass = 1'b0;
            if (rxdv)
                state_d = S_WAIT;
        end
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            etype_hi_q <= '0;
            vlan_q     <= '0;
            dst_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            etype_hi_q <= etype_hi_d;
            vlan_q     <= vlan_d;
            dst_q      <= dst_d;
        end
    end

    logic [8:0] dly_q [DELAY];

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++)
                dly_q[i] <= '0;
        end else begin
            dly_q[0] <= {rxdv, rxd};
            for (int i = 1; i < DELAY; i++)
                dly_q[i] <= dly_q[i-1];
        end
    end

    logic       dly_dv;
    logic [7:0] dly_d;
    assign dly_dv = dly_q[DELAY-1][8];
    assign dly_d  = dly_q[DELAY-1][7:0];

    // Decision FIFO: one bit per frame, head consumed as the delayed frame starts.
    logic       fifo_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] fcnt_q, fcnt_d;
    logic       dly_dv_prev_q, keep_q, keep_d;
    logic       dly_rise, pop, push_ok;
    logic       txen_q, txen_d;
    logic [7:0] txd_q, txd_d;

    always_comb begin
        dly_rise = dly_dv && !dly_dv_prev_q;
        pop      = dly_rise && (fcnt_q != 3'd0);
        push_ok  = push && ((fcnt_q != 3'd4) || pop);
        fcnt_d   = fcnt_q;
        case ({push_ok, pop})
            2'b10:   fcnt_d = fcnt_q + 3'd1;
            2'b01:   fcnt_d = fcnt_q - 3'd1;
            default: fcnt_d = fcnt_q;
        endcase
        keep_d = keep_q;
        if (dly_rise)
            keep_d = pop ? fifo_q[rd_q] : 1'b0;
        txen_d = dly_dv && keep_d;
        txd_d  = txen_d ? dly_d : 8'h00;
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                fifo_q[i] <= 1'b0;
            wr_q          <= '0;
            rd_q          <= '0;
            fcnt_q        <= '0;
            dly_dv_prev_q <= 1'b0;
            keep_q        <= 1'b0;
            txen_q        <= 1'b0;
            txd_q         <= '0;
        end else begin
            if (push_ok) begin
                fifo_q[wr_q] <= push_pass;
                wr_q         <= wr_q + 2'd1;
            end
            if (pop)
                rd_q <= rd_q + 2'd1;
            fcnt_q        <= fcnt_d;
            dly_dv_prev_q <= dly_dv;
            keep_q        <= keep_d;
            txen_q        <= txen_d;
            txd_q         <= txd_d;
        end
    end

    assign txen = txen_q;
    assign txd  = txd_q;

endmodule

// File: tb/tb_gmii_mac.sv
// Randomized scoreboard bench for gmii_mac: a frame-level reference model predicts which frames
// come back out and at which cycle; a negedge monitor pops and compares every transmitted byte.
`timescale 1ns/1ps
module tb_gmii_mac;

    localparam int          DELAY = 64;
    localparam logic [31:0] IP2   = 32'hC0A86466;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int         cyc;
        logic [7:0] d;
    } exp_t;

    logic       rx_clk = 1'b0;
    logic       sys_clk = 1'b0;
    logic       reset;
    logic [7:0] rxd;
    logic       rxdv;
    logic       rxer;
    logic       gtx_clk;
    logic [7:0] txd;
    logic       txen;

    gmii_mac dut (
        .rx_clk  (rx_clk),
        .reset   (reset),
        .sys_clk (sys_clk),
        .rxd     (rxd),
        .rxdv    (rxdv),
        .rxer    (rxer),
        .gtx_clk (gtx_clk),
        .txd     (txd),
        .txen    (txen)
    );

    always #5 rx_clk  = ~rx_clk;
    always #7 sys_clk = ~sys_clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t e;

    always @(posedge rx_clk) cyc <= cyc + 1;

    always @(negedge rx_clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_byte: txen low at cycle %0d, required txd=%h at cycle %0d", cyc, e.d, e.cyc);
            end
            checks++;
            if (txen) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_txen: txen=1 txd=%h at cycle %0d, required txen=0", txd, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.d != txd) begin
                        errors++;
                        $display("FAIL tx_byte: got txd=%h at cycle %0d, required txd=%h at cycle %0d", txd, cyc, e.d, e.cyc);
                    end
                end
            end else if (txd != 8'h00) begin
                errors++;
                $display("FAIL idle_txd: txd=%h with txen=0 at cycle %0d, required 00", txd, cyc);
            end
        end
    end

    // Frame-level model: walk the byte list as the header layout defines it.
    function automatic bit ref_accept(input bq_t f, input int er_idx);
        int          n;
        int          i;
        int          p;
        int          tags;
        int          ip;
        logic [31:0] dst;
        n = f.size();
        i = 0;
        while (i < n && f[i] == 8'h55) i++;
        if (i < 7 || i >= n || f[i] != 8'h5D) return 1'b0;
        p    = i + 13;
        tags = 0;
        while (p + 1 < n && {f[p], f[p+1]} == 16'h8100) begin
            tags++;
            if (tags > 2) return 1'b0;
            p += 4;
        end
        if (p + 1 >= n || {f[p], f[p+1]} != 16'h0800) return 1'b0;
        ip = p + 2;
        if (ip + 19 >= n) return 1'b0;
        if (er_idx >= 0 && er_idx <= ip + 19) return 1'b0;
        dst = {f[ip+16], f[ip+17], f[ip+18], f[ip+19]};
        return dst == IP2;
    endfunction

    function automatic bq_t build(input int npre, input int ntags, input logic [15:0] etype,
                                  input logic [31:0] dst, input int npay);
        bq_t f;
        for (int k = 0; k < npre; k++) f.push_back(8'h55);
        f.push_back(8'h5D);
        f.push_back(8'h38); f.push_back(8'h6b); f.push_back(8'h1c);
        f.push_back(8'h1d); f.push_back(8'hf5); f.push_back(8'h65);
        for (int k = 0; k < 6; k++) f.push_back(8'($urandom_range(0, 255)));
        for (int t = 0; t < ntags; t++) begin
            f.push_back(8'h81); f.push_back(8'h00);
            f.push_back(t == 0 ? 8'hEE : (t == 1 ? 8'hFF : 8'h12));
            f.push_back(t == 0 ? 8'hEF : (t == 1 ? 8'hFE : 8'h34));
        end
        f.push_back(etype[15:8]); f.push_back(etype[7:0]);
        f.push_back(8'h45);
        for (int k = 1; k < 12; k++) f.push_back(8'($urandom_range(0, 255)));
        f.push_back(8'h5b); f.push_back(8'h69); f.push_back(8'hc0); f.push_back(8'h64);
        f.push_back(dst[31:24]); f.push_back(dst[23:16]); f.push_back(dst[15:8]); f.push_back(dst[7:0]);
        for (int k = 0; k < npay; k++) f.push_back(8'(8'h0A + k));
        return f;
    endfunction

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        rxdv = dv;
        rxd  = d;
        rxer = er;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic send(input bq_t f, input int er_idx, input int gap);
        bit   acc;
        exp_t x;
        acc = ref_accept(f, er_idx);
        for (int k = 0; k < f.size(); k++) begin
            if (acc) begin
                x.cyc = cyc + DELAY + 1;
                x.d   = f[k];
                sb.push_back(x);
            end
            drive(1'b1, f[k], k == er_idx);
        end
        for (int k = 0; k < gap; k++)
            drive(1'b0, ($urandom_range(0, 1) == 0) ? 8'h55 : 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    endtask

    bq_t f2, ft, fr;
    int  t;

    initial begin
        reset = 1'b1;
        rxd   = 8'h00;
        rxdv  = 1'b0;
        rxer  = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        checks++;
        if (txen !== 1'b0 || txd !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: txen=%b txd=%h, required txen=0 txd=00", txen, txd);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        // 55s without rxdv, then a lone non-preamble byte
        for (int k = 0; k < 30; k++) drive(1'b0, 8'h55, 1'b0);
        ft = {};
        ft.push_back(8'h11);
        send(ft, -1, 30);

        f2 = build(8, 2, 16'h0800, IP2, 8);
        send(f2, -1, 12);
        send(build(8, 1, 16'h0800, 32'hC0A80166, 80), -1, 5);
        send(build(8, 2, 16'h86DD, IP2, 8), -1, 3);
        send(build(8, 3, 16'h0800, IP2, 8), -1, 1);
        send(f2, 10, 2);
        send(f2, -1, 1);
        send(build(5, 2, 16'h0800, IP2, 8), -1, 4);
        ft = f2[0:40];
        send(ft, -1, 3);
        send(build(7, 0, 16'h0800, IP2, 0), -1, 1);
        send(f2, 55, 2);

        for (int r = 0; r < 40; r++) begin
            int          er_idx;
            logic [15:0] et;
            logic [31:0] dst;
            case ($urandom_range(0, 7))
                0:       et = 16'h86DD;
                1:       et = 16'h0806;
                default: et = 16'h0800;
            endcase
            dst = ($urandom_range(0, 1) == 0) ? IP2 : (IP2 ^ (32'd1 << $urandom_range(0, 31)));
            fr = build($urandom_range(5, 10), $urandom_range(0, 3), et, dst, $urandom_range(0, 30));
            if ($urandom_range(0, 5) == 0 && fr.size() > 25)
                fr = fr[0:$urandom_range(23, fr.size() - 2)];
            er_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, fr.size() - 1) : -1;
            send(fr, er_idx, $urandom_range(1, 6));
        end
        for (int k = 0; k < DELAY + 20; k++) drive(1'b0, 8'h55, 1'b0);

        // Reset in the middle of a forwarded frame
        send(f2, -1, 0);
        t = 0;
        while (!txen && t < 200) begin
            drive(1'b0, 8'h00, 1'b0);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL fwd_timeout: txen=%b after %0d cycles, required 1", txen, t);
        end
        repeat (5) drive(1'b0, 8'h00, 1'b0);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        checks++;
        if (txen !== 1'b0 || txd !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_frame: txen=%b txd=%h, required txen=0 txd=00", txen, txd);
        end
        sb.delete();
        @(posedge rx_clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        send(f2, -1, DELAY + 20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected bytes never transmitted, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
